regfile_scoreboard: RTL
=======================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each register in bits.
REQ-002 Parameter NUM_REG, default 32, number of architectural registers (at most 2**ADD_WIDTH).
REQ-003 Parameter ADD_WIDTH, default 5, width of every register address.
REQ-004 Parameter BYPASS, default 1, write-to-read forwarding enable: 1 = same-cycle forwarding on, 0 = off.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1, rising-edge clock for all state.
REQ-007 Port rst, input, 1, synchronous active-high reset.
REQ-008 Ports rd_addr_1/2/3, input, ADD_WIDTH each, read addresses.
REQ-009 Ports rd_data_1/2/3, output, DATA_WIDTH each, combinational read data.
REQ-010 Port wr_en, input, 1, writeback strobe.
REQ-011 Port wr_addr, input, ADD_WIDTH, writeback destination.
REQ-012 Port wr_data, input, DATA_WIDTH, writeback value.
REQ-013 Port iss_valid, input, 1, instruction issue request.
REQ-014 Ports iss_src1, iss_src2, iss_dst, input, ADD_WIDTH each, issuing instruction's sources and destination.
REQ-015 Port iss_stall, output, 1, combinational hazard stall.
REQ-016 Port busy_vec, output, NUM_REG, registered pending-write bit per register.
REQ-017 Port busy_cnt, output, ADD_WIDTH+1, registered count of set busy bits.
REQ-018 Port wb_err, output, 1, sticky flag for writeback to a non-busy register.

Function
REQ-019 Register 0 SHALL read as 0, ignore writes, and never be marked busy.
REQ-020 rd_data_n SHALL equal the stored value of rd_addr_n, or 0 when rd_addr_n >= NUM_REG.
REQ-021 With BYPASS=1, wr_en=1 and rd_addr_n==wr_addr!=0, rd_data_n SHALL equal wr_data in the same cycle.
REQ-022 On a clk edge with wr_en=1, wr_addr!=0 and wr_addr<NUM_REG, the register SHALL take wr_data; the write is visible one cycle later without bypass.
REQ-023 A register is pending when busy_vec[r]=1 and not (wr_en=1 and wr_addr=r) in the current cycle (writeback clears the hazard in the same cycle).
REQ-024 iss_stall SHALL be 1 iff iss_valid=1 and any of iss_src1, iss_src2 or iss_dst is pending (RAW and WAW).
REQ-025 Issue is accepted on a clk edge when iss_valid=1 and iss_stall=0; busy_vec[iss_dst] SHALL then be set unless iss_dst=0.
REQ-026 On a clk edge with wr_en=1, busy_vec[wr_addr] SHALL clear.
REQ-027 If an accepted issue and a writeback target the same register on the same edge, the set SHALL win and busy stays 1.
REQ-028 busy_cnt SHALL track the number of set bits in busy_vec, updating in the same cycle as busy_vec with net change -1, 0 or +1.
REQ-029 wb_err SHALL set on a clk edge when wr_en=1, wr_addr!=0 and busy_vec[wr_addr]=0; it remains set until reset.
REQ-030 An address >= NUM_REG on the write or issue ports SHALL be ignored for state and treated as never pending.

Reset
REQ-031 With rst=1 on a clk edge, all registers, busy_vec, busy_cnt and wb_err SHALL become 0; rst has priority over write and issue on that edge.
REQ-032 During reset, iss_stall SHALL follow REQ-024 combinationally from the (zero) busy state.

Verification
REQ-033 Reset, then write r5=0xDEADBEEF -> next cycle rd_data_1 (addr 5)=0xDEADBEEF and wb_err=1 (r5 was not busy).
REQ-034 BYPASS=1: wr_en with wr_addr=7 and wr_data=0x12 while rd_addr_2=7 -> rd_data_2=0x12 in the same cycle; BYPASS=0 -> old value.
REQ-035 Issue dst=3, then issue src1=3 -> iss_stall=1 until wr_en with wr_addr=3; stall=0 in the writeback cycle; busy_cnt goes 1 -> 0.
REQ-036 Issue dst=4 on the same edge as writeback wr_addr=4 (r4 busy) -> busy_vec[4] stays 1 and busy_cnt is unchanged.
REQ-037 Issue dst=0 and write r0=0xFFFF -> busy_vec[0]=0, rd_data (addr 0)=0, no stall on src=0.
REQ-038 rst asserted with 3 registers busy and a concurrent issue -> next cycle busy_vec=0, busy_cnt=0, wb_err=0, and all reads return 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Three-read, one-write register file with a per-register busy scoreboard.
// Flags RAW/WAW hazards on issue and tracks the number of pending writes.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REG    = 32,
  parameter int ADD_WIDTH  = 5,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADD_WIDTH-1:0]  rd_addr_1,
  input  logic [ADD_WIDTH-1:0]  rd_addr_2,
  input  logic [ADD_WIDTH-1:0]  rd_addr_3,
  output logic [DATA_WIDTH-1:0] rd_data_1,
  output logic [DATA_WIDTH-1:0] rd_data_2,
  output logic [DATA_WIDTH-1:0] rd_data_3,
  input  logic                  wr_en,
  input  logic [ADD_WIDTH-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  iss_valid,
  input  logic [ADD_WIDTH-1:0]  iss_src1,
  input  logic [ADD_WIDTH-1:0]  iss_src2,
  input  logic [ADD_WIDTH-1:0]  iss_dst,
  output logic                  iss_stall,
  output logic [NUM_REG-1:0]    busy_vec,
  output logic [ADD_WIDTH:0]    busy_cnt,
  output logic                  wb_err
);

  localparam logic [ADD_WIDTH:0] NumRegW = (ADD_WIDTH+1)'(NUM_REG);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REG];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REG];
  logic [NUM_REG-1:0]    busy_q, busy_d;
  logic [ADD_WIDTH:0]    cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic [ADD_WIDTH-1:0]  rdAddr [3];
  logic [DATA_WIDTH-1:0] rdData [3];
  logic                  wrHit, issStall, issAccept, incCnt, decCnt;

  function automatic logic inRange(input logic [ADD_WIDTH-1:0] a);
    return ({1'b0, a} < NumRegW);
  endfunction

  // Out-of-range addresses read back as not busy, so they never stall.
  function automatic logic busyAt(input logic [NUM_REG-1:0] vec,
                                  input logic [ADD_WIDTH-1:0] a);
    logic b;
    b = 1'b0;
    for (int r = 0; r < NUM_REG; r++)
      if (a == ADD_WIDTH'(r)) b = vec[r];
    return b;
  endfunction

  function automatic logic isPending(input logic [NUM_REG-1:0]   vec,
                                     input logic                 we,
                                     input logic [ADD_WIDTH-1:0] wa,
                                     input logic [ADD_WIDTH-1:0] a);
    return busyAt(vec, a) && !(we && (wa == a));
  endfunction

  assign wrHit     = wr_en && inRange(wr_addr) && (wr_addr != '0);
  assign rdAddr[0] = rd_addr_1;
  assign rdAddr[1] = rd_addr_2;
  assign rdAddr[2] = rd_addr_3;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rdData[p] = '0;
      for (int r = 1; r < NUM_REG; r++)
        if (rdAddr[p] == ADD_WIDTH'(r)) rdData[p] = regs_q[r];
      if ((BYPASS != 0) && wrHit && (wr_addr == rdAddr[p])) rdData[p] = wr_data;
    end
  end

  assign rd_data_1 = rdData[0];
  assign rd_data_2 = rdData[1];
  assign rd_data_3 = rdData[2];

  always_comb begin
    for (int r = 0; r < NUM_REG; r++) regs_d[r] = regs_q[r];
    for (int r = 1; r < NUM_REG; r++)
      if (wrHit && (wr_addr == ADD_WIDTH'(r))) regs_d[r] = wr_data;
    regs_d[0] = '0;
  end

  // Writeback clears a hazard in its own cycle; an issue to the same register wins the edge.
  always_comb begin
    issStall  = iss_valid && (isPending(busy_q, wr_en, wr_addr, iss_src1) ||
                              isPending(busy_q, wr_en, wr_addr, iss_src2) ||
                              isPending(busy_q, wr_en, wr_addr, iss_dst));
    issAccept = iss_valid && !issStall && (iss_dst != '0) && inRange(iss_dst);
    busy_d    = busy_q;
    for (int r = 1; r < NUM_REG; r++) begin
      if (wr_en && (wr_addr == ADD_WIDTH'(r))) busy_d[r] = 1'b0;
      if (issAccept && (iss_dst == ADD_WIDTH'(r))) busy_d[r] = 1'b1;
    end
    busy_d[0] = 1'b0;
    incCnt    = issAccept && !busyAt(busy_q, iss_dst);
    decCnt    = wrHit && busyAt(busy_q, wr_addr) && !(issAccept && (iss_dst == wr_addr));
    cnt_d     = cnt_q + (ADD_WIDTH+1)'(incCnt) - (ADD_WIDTH+1)'(decCnt);
    err_d     = err_q | (wrHit && !busyAt(busy_q, wr_addr));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REG; r++) regs_q[r] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REG; r++) regs_q[r] <= regs_d[r];
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign iss_stall = issStall;
  assign busy_vec  = busy_q;
  assign busy_cnt  = cnt_q;
  assign wb_err    = err_q;

endmodule
